// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter request/grant client: state codes,
// default sizing and the arbiter-side phase codes used by bench models.
package arb_pkg;

  localparam int LEN_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;
  localparam int QUIET_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } client_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_GRANT = 2'd2,
    ARB_DROP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_client.sv
// Requester-side agent for the 4-way req/gnt arbiter: takes a job of
// job_len+1 beats, holds req until granted, streams beats, then releases.
module arb_client
  import arb_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int QUIET   = QUIET_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_idx,
  output logic             done,
  output logic             timeout,
  output logic             abort,
  output logic             busy
);

  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [2:0] QUIET_LAST = 3'(QUIET - 1);

  client_state_e    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       wait_q, wait_d;
  logic [2:0]       quiet_q, quiet_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic             abort_q, abort_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      quiet_q <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      quiet_q <= quiet_d;
      req_q   <= req_d;
      done_q  <= done_d;
      to_q    <= to_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    quiet_d = quiet_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (job_valid && job_ready) begin
          state_d = REQ;
          len_d   = job_len;
          wait_d  = '0;
        end
      end
      REQ: begin
        // A grant sampled on the expiry cycle still wins over the timeout.
        if (gnt) begin
          state_d = XFER;
          idx_d   = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = RELEASE;
          to_d    = 1'b1;
          quiet_d = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      XFER: begin
        if (!gnt) begin
          state_d = RELEASE;
          abort_d = 1'b1;
          quiet_d = '0;
        end else if (idx_q == len_q) begin
          state_d = RELEASE;
          done_d  = 1'b1;
          quiet_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RELEASE: begin
        // Wait out any late or lingering grant before re-arming.
        if (gnt) begin
          quiet_d = '0;
        end else if (quiet_q == QUIET_LAST) begin
          state_d = IDLE;
        end else begin
          quiet_d = quiet_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ) || (state_d == XFER);
  end

  assign job_ready  = (state_q == IDLE) && !reset;
  assign req        = req_q;
  assign beat_valid = (state_q == XFER) && gnt;
  assign beat_idx   = idx_q;
  assign done       = done_q;
  assign timeout    = to_q;
  assign abort      = abort_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_arb_client.sv
// Randomized scoreboard bench for arb_client: per-job grant plans feed both a
// gnt driver and an outcome model; a monitor checks beats, pulses and timing.
module tb_arb_client;
  import arb_pkg::*;

  localparam int LW    = LEN_W_DEF;
  localparam int TO    = TIMEOUT_DEF;
  localparam int QT    = QUIET_DEF;
  localparam int NJOBS = 60;

  typedef enum int {K_DONE = 0, K_TIMEOUT = 1, K_ABORT = 2} kind_e;
  typedef struct {
    kind_e kind;
    int    nbeats;
    int    reqlen;
    int    dwell;
  } exp_t;
  typedef struct {
    int d;
    int g;
  } plan_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          job_valid;
  logic          job_ready;
  logic [LW-1:0] job_len;
  logic          req;
  logic          gnt;
  logic          beat_valid;
  logic [LW-1:0] beat_idx;
  logic          done;
  logic          timeout;
  logic          abort;
  logic          busy;

  logic gnt_plan = 1'b0;
  logic gnt_dir  = 1'b0;
  bit   rand_phase = 1'b0;
  assign gnt = rand_phase ? gnt_plan : gnt_dir;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    total = 0;
  int    bad   = 0;

  arb_client #(.LEN_W(LW), .TIMEOUT(TO), .QUIET(QT)) dut (
    .clock(clock), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_len(job_len), .req(req), .gnt(gnt), .beat_valid(beat_valid),
    .beat_idx(beat_idx), .done(done), .timeout(timeout), .abort(abort),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Grant level k cycles after req was first seen high.
  function automatic bit gsched(input int d, input int g, input int k);
    return (k >= d) && (k < d + g);
  endfunction

  // Outcome of one job from its grant plan: wait d cycles, then grant for g.
  function automatic exp_t model(input int len, input int d, input int g);
    exp_t e;
    int n, r, q, run;
    n = len + 1;
    if (d >= TO) begin
      e.kind = K_TIMEOUT; e.nbeats = 0; e.reqlen = TO; r = TO;
    end else if (g - 1 >= n) begin
      e.kind = K_DONE; e.nbeats = n; e.reqlen = d + n + 1; r = d + n + 1;
    end else begin
      e.kind = K_ABORT; e.nbeats = g - 1; e.reqlen = d + g + 1; r = d + g + 1;
    end
    run = 0;
    q = r;
    for (int i = 0; i < 1000; i++) begin
      q = r + i;
      if (gsched(d, g, q)) run = 0;
      else run++;
      if (run == QT) break;
    end
    e.dwell = q + 1 - r;
    return e;
  endfunction

  // Arbiter stand-in: replays the next plan each time req rises.
  initial begin
    plan_t p;
    int    k = 0;
    bit    act = 1'b0;
    logic  prev = 1'b0;
    arb_state_e ph = ARB_IDLE;
    forever begin
      @(posedge clock); #1;
      if (rand_phase) begin
        if (req && !prev) begin
          chk("plan_avail", int'(plan_q.size() > 0), 1);
          if (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            act = 1'b1;
            k = 0;
          end
        end
        if (act) begin
          gnt_plan = gsched(p.d, p.g, k);
          ph = gnt_plan ? ARB_GRANT : (k < p.d ? ARB_WAIT : ARB_DROP);
          k++;
          if (k > p.d + p.g) act = 1'b0;
        end else begin
          gnt_plan = 1'b0;
          ph = ARB_IDLE;
        end
      end
      prev = req;
    end
  end

  // Monitor: beats in order, one terminal pulse per job, req span, dwell.
  initial begin
    exp_t  e;
    int    bcnt = 0, run = 0, last_run = 0, dw = 0, k;
    bit    in_dw = 1'b0;
    forever begin
      @(negedge clock);
      if (rand_phase) begin
        if (req) run++;
        else begin
          if (run != 0) last_run = run;
          run = 0;
        end
        if (in_dw) begin
          dw++;
          if (job_ready || dw > 200) begin
            chk("release_dwell", dw, e.dwell);
            in_dw = 1'b0;
          end
        end
        if (beat_valid) begin
          chk("beat_pending", int'(exp_q.size() > 0), 1);
          chk("beat_idx", int'(beat_idx), bcnt);
          bcnt++;
        end
        if (done || timeout || abort) begin
          chk("pulse_onehot", $countones({done, timeout, abort}), 1);
          chk("pulse_pending", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            k = done ? int'(K_DONE) : (timeout ? int'(K_TIMEOUT) : int'(K_ABORT));
            chk("term_kind", k, int'(e.kind));
            chk("beat_count", bcnt, e.nbeats);
            chk("req_span", last_run, e.reqlen);
            chk("req_low_at_pulse", int'(req), 0);
            in_dw = 1'b1;
            dw = 0;
          end
          bcnt = 0;
        end
      end
    end
  end

  initial begin
    int  len, d, g, gap;
    bit  got, stuck;
    reset = 1'b1; job_valid = 1'b0; job_len = '0; gnt_dir = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_job_ready_low", int'(job_ready), 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_req", int'(req), 0);
    chk("rst_job_ready", int'(job_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_beat_idx", int'(beat_idx), 0);
    chk("rst_pulses", int'({done, timeout, abort}), 0);

    // Reset while streaming beat 2 of an 8-beat job.
    @(posedge clock); #1;
    job_valid = 1'b1; job_len = LW'(7); gnt_dir = 1'b1;
    @(posedge clock); #1 job_valid = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clock);
      if (beat_valid && beat_idx == LW'(2)) begin got = 1'b1; break; end
    end
    chk("reach_beat2", int'(got), 1);
    reset = 1'b1;
    #1 chk("mid_rst_job_ready", int'(job_ready), 0);
    @(negedge clock);
    chk("mid_rst_req", int'(req), 0);
    chk("mid_rst_beat_valid", int'(beat_valid), 0);
    chk("mid_rst_beat_idx", int'(beat_idx), 0);
    chk("mid_rst_pulses", int'({done, timeout, abort}), 0);
    chk("mid_rst_job_ready_held", int'(job_ready), 0);
    @(posedge clock); #1 reset = 1'b0; gnt_dir = 1'b0;
    @(negedge clock);
    chk("post_rst_job_ready", int'(job_ready), 1);

    @(posedge clock); #1 rand_phase = 1'b1;
    stuck = 1'b0;
    for (int j = 0; j < NJOBS; j++) begin
      len = (j % 3 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0, 1:    d = $urandom_range(0, 4);
        2:       d = $urandom_range(TO - 2, TO + 3);
        default: d = $urandom_range(0, TO + 3);
      endcase
      if ($urandom_range(0, 1) == 0) g = len + 2 + $urandom_range(0, 3);
      else g = $urandom_range(1, len + 5);
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3));
      job_valid = 1'b1;
      job_len = LW'(len);
      got = 1'b0;
      for (int w = 0; w < 400; w++) begin
        @(negedge clock);
        if (job_ready) begin got = 1'b1; break; end
      end
      chk("accept_wait", int'(got), 1);
      if (!got) begin stuck = 1'b1; break; end
      exp_q.push_back(model(len, d, g));
      plan_q.push_back('{d: d, g: g});
      @(posedge clock); #1;
      if (gap > 0) begin
        job_valid = 1'b0;
        repeat (gap) @(posedge clock);
        #1;
      end
    end
    job_valid = 1'b0;
    if (!stuck) begin
      got = 1'b0;
      for (int w = 0; w < 400; w++) begin
        @(negedge clock);
        if (exp_q.size() == 0 && job_ready && !busy) begin got = 1'b1; break; end
      end
      chk("drain", int'(got), 1);
    end
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
